// File: rtl/scan_pkg.sv
// Shared types and constants for the scan-chain controller.
// The optional MISR signature is enabled by defining SCAN_MISR_EN.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef enum logic {
    LOAD   = 1'b0,
    UNLOAD = 1'b1
  } mode_t;

  // CRC-32 generator polynomial used by the response signature.
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

  function automatic int cnt_width(input int chain_len, input int capture_cyc);
    int m;
    m = (chain_len > capture_cyc) ? chain_len : capture_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/scan_misr.sv
// Serial-input MISR: left shift, feedback = msb ^ din, XOR with POLY.
// Instantiated by scan_chain_ctrl only when SCAN_MISR_EN is defined.
module scan_misr
  import scan_pkg::*;
#(
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY)
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic fb;
  assign fb = sig[SIG_W-1] ^ din;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan-chain controller: loads patterns, captures, unloads responses.
// Define SCAN_MISR_EN to compress kept unload bits into a MISR signature.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN   = 32,
  parameter int CAPTURE_CYC = 1,
  parameter int SIG_W       = 32
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic                 unload_req,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [CHAIN_LEN-1:0] resp_data,
  output logic                 scan_se,
  output logic                 scan_si,
  input  logic                 scan_so,
  output logic                 busy,
  input  logic                 sig_clr,
  output logic [SIG_W-1:0]     signature
);

  localparam int CW = cnt_width(CHAIN_LEN, CAPTURE_CYC);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CAP_LAST   = CW'(CAPTURE_CYC - 1);

  // Handshakes: a transfer happens on a rising CLK edge where valid && ready;
  // valid never drops and data never changes until that edge.
  state_t               state_q, state_d;
  mode_t                mode_q, mode_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] shift_q, shift_d;
  logic [CHAIN_LEN-1:0] resp_data_d;
  logic                 resp_valid_d, resp_pend_q, resp_pend_d;
  logic                 se_d, si_d, busy_d, pat_ready_d;
  logic                 capture_pending, capture_pending_d;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q         <= IDLE;
      mode_q          <= LOAD;
      cnt_q           <= '0;
      pat_q           <= '0;
      shift_q         <= '0;
      resp_data       <= '0;
      resp_valid      <= 1'b0;
      resp_pend_q     <= 1'b0;
      scan_se         <= 1'b0;
      scan_si         <= 1'b0;
      busy            <= 1'b0;
      pat_ready       <= 1'b1;
      capture_pending <= 1'b0;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      cnt_q           <= cnt_d;
      pat_q           <= pat_d;
      shift_q         <= shift_d;
      resp_data       <= resp_data_d;
      resp_valid      <= resp_valid_d;
      resp_pend_q     <= resp_pend_d;
      scan_se         <= se_d;
      scan_si         <= si_d;
      busy            <= busy_d;
      pat_ready       <= pat_ready_d;
      capture_pending <= capture_pending_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    mode_d            = mode_q;
    cnt_d             = cnt_q;
    pat_d             = pat_q;
    shift_d           = shift_q;
    resp_data_d       = resp_data;
    resp_valid_d      = resp_valid;
    resp_pend_d       = 1'b0;
    se_d              = scan_se;
    si_d              = scan_si;
    capture_pending_d = capture_pending;

    if (resp_valid && resp_ready) resp_valid_d = 1'b0;
    if (resp_pend_q)              resp_valid_d = 1'b1;

    case (state_q)
      IDLE: begin
        // pat_ready already encodes IDLE with no response outstanding.
        if (pat_valid && pat_ready) begin
          pat_d   = pat_data >> 1;
          si_d    = pat_data[0];
          se_d    = 1'b1;
          cnt_d   = '0;
          mode_d  = LOAD;
          state_d = SHIFT;
        end else if (unload_req && capture_pending && pat_ready) begin
          pat_d   = '0;
          si_d    = 1'b0;
          se_d    = 1'b1;
          cnt_d   = '0;
          mode_d  = UNLOAD;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // First SO sample migrates down to bit 0 after CHAIN_LEN shifts.
        shift_d = (shift_q >> 1) | (CHAIN_LEN'(scan_so) << (CHAIN_LEN - 1));
        si_d    = pat_q[0];
        pat_d   = pat_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == SHIFT_LAST) begin
          cnt_d = '0;
          se_d  = 1'b0;
          si_d  = 1'b0;
          if (capture_pending) begin
            resp_data_d = shift_d;
            resp_pend_d = 1'b1;
          end
          if (mode_q == LOAD) begin
            state_d = CAPTURE;
          end else begin
            state_d           = IDLE;
            capture_pending_d = 1'b0;
          end
        end
      end
      CAPTURE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CAP_LAST) begin
          cnt_d             = '0;
          state_d           = IDLE;
          capture_pending_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    pat_ready_d = (state_d == IDLE) && !resp_valid_d && !resp_pend_d;
  end

`ifdef SCAN_MISR_EN
  scan_misr #(
    .SIG_W(SIG_W),
    .POLY (SIG_W'(MISR_POLY))
  ) u_misr (
    .CLK (CLK),
    .RSTB(RSTB),
    .clr (sig_clr),
    .en  ((state_q == SHIFT) && capture_pending),
    .din (scan_so),
    .sig (signature)
  );
`else
  logic unused_sig_clr;
  assign unused_sig_clr = sig_clr;
  assign signature      = '0;
`endif

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Serial scan-test controller that drives one chain of scan flip-flops (SE/SI/Q cells with async active-low reset) and consumes the chain's serial output.
- Accepts parallel test patterns over a valid/ready handshake and shifts each one into the chain.
- Issues capture cycles, then unloads the captured response while the next pattern shifts in.
- Returns each response as a parallel word over a second valid/ready handshake.

Parameters:
- CHAIN_LEN, 32, number of scan cells in the chain; must be ≥2.
- CAPTURE_CYC, 1, number of capture cycles (SE low) after each load; must be ≥1.
- SIG_W, 32, MISR signature width (used only with the optional feature).

Ports:
- CLK  in  1  clock; the chain is clocked by the same clock.
- RSTB  in  1  asynchronous active-low reset.
- pat_valid  in  1  pattern offered.
- pat_ready  out  1  controller can accept a pattern.
- pat_data  in  CHAIN_LEN  pattern; bit 0 shifted first.
- unload_req  in  1  request a final unload-only shift, SI filled with 0.
- resp_valid  out  1  response word valid.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  CHAIN_LEN  captured response; bit 0 is the first SO bit sampled.
- scan_se  out  1  chain scan enable.
- scan_si  out  1  chain serial input.
- scan_so  in  1  Q of the last cell in the chain.
- busy  out  1  high in SHIFT or CAPTURE.
- sig_clr  in  1  synchronous signature clear.
- signature  out  SIG_W  MISR value.

Behaviour:
- Reset (RSTB low, asynchronous):
  - state=IDLE; scan_se=0, scan_si=0, resp_valid=0, resp_data=0, busy=0, signature=0, capture_pending=0.
  - Reset asserted mid-shift aborts the operation immediately; no response is produced.
- All outputs are registered. pat_ready = (state==IDLE) && !resp_valid, registered-equivalent and glitch-free.
- IDLE:
  - pat_valid && pat_ready: latch pat_data; scan_se<=1; scan_si<=pat_data[0]; cnt<=0; go to SHIFT with mode=LOAD.
  - Otherwise, if unload_req && capture_pending && !resp_valid: scan_se<=1; scan_si<=0; go to SHIFT with mode=UNLOAD.
  - pat_valid has priority over unload_req.
  - unload_req while capture_pending=0 is ignored.
- SHIFT lasts exactly CHAIN_LEN cycles with scan_se=1. At each edge:
  - resp_shift[cnt]<=scan_so.
  - scan_si<=pattern bit cnt+1 (mode LOAD) or 0 (mode UNLOAD).
  - cnt++.
- At the end of SHIFT (cnt==CHAIN_LEN-1 edge):
  - If capture_pending was 1 at entry: resp_data<=collected bits, resp_valid<=1 on the following cycle. Otherwise the unloaded bits are discarded.
  - Mode LOAD: scan_se<=0 and go to CAPTURE. Mode UNLOAD: go to IDLE with capture_pending<=0.
- CAPTURE lasts CAPTURE_CYC cycles with scan_se=0 and scan_si=0, then goes to IDLE with capture_pending<=1.
- Response handshake: resp_valid stays high, with resp_data stable, until a resp_valid && resp_ready edge; it clears on that edge.
- No pattern or unload is started while resp_valid=1, so responses are never overwritten.
- Bit mapping: after a LOAD, pat_data[i] sits in cell CHAIN_LEN-1-i (cell CHAIN_LEN-1 drives scan_so). resp_data[i] is the captured value of cell CHAIN_LEN-1-i.
  - Consequently, a chain whose capture holds Q returns resp_data == pat_data.
- Latency:
  - Pattern accept to first shift edge: 1 cycle.
  - Accept to resp_valid of the previous response: CHAIN_LEN+1 cycles.
  - Accept of pattern N to pat_ready again: CHAIN_LEN+CAPTURE_CYC+1 cycles, provided the response was consumed.

Optional Feature:
- SCAN_MISR_EN defined:
  - signature is a SIG_W-bit serial-input MISR, polynomial CRC-32 0x04C11DB7 (for SIG_W=32), shifting left.
  - Feedback bit = signature[SIG_W-1] ^ scan_so; updated on every SHIFT edge where the unloaded bit is kept (capture_pending=1).
  - sig_clr zeroes it and has priority over an update in the same cycle.
- SCAN_MISR_EN undefined: signature tied to 0, sig_clr ignored, port list unchanged.

Decomposition:
- Package scan_pkg:
  - State enum {IDLE, SHIFT, CAPTURE}.
  - Mode enum {LOAD, UNLOAD}.
  - Default MISR polynomial constant.
  - Function computing counter width = clog2(max(CHAIN_LEN, CAPTURE_CYC)+1).
- One natural sub-module: scan_misr (SIG_W, POLY), instantiated only under SCAN_MISR_EN.

Test Plan:
1. Loopback model (captured D=Q), CHAIN_LEN=8:
   - Pattern 0xA5 gives no response.
   - Pattern 0x3C then produces resp_data=0xA5 exactly 9 cycles after the 0x3C accept.
2. Inverting-capture model (D=~Q): patterns 0xA5 then 0xFF → resp_data=0x5A; unload_req → resp_data=0x00; capture_pending ends 0, scan_si=0 throughout the unload.
3. Back-pressure: hold resp_ready=0 for 20 cycles after resp_valid → resp_data stable, pat_ready=0, unload_req ignored; response releases on resp_ready=1.
4. Simultaneous pat_valid and unload_req in IDLE → LOAD taken, scan_si follows pat_data bits; unload_req with capture_pending=0 → no shift, busy stays 0.
5. RSTB low at shift cycle 4 → scan_se=0 and resp_valid=0 asynchronously; the next pattern after reset produces no response (capture_pending=0).
6. SCAN_MISR_EN, loopback, patterns 0x01,0x02,0x00:
   - signature matches the reference model after the 0x02 and 0x00 unloads.
   - sig_clr asserted during an update edge leaves signature=0.
